prog_counter: RTL and testbench

Parametrised, programmable successor to the board's free-running LED counter. It counts at a prescaled rate with selectable direction and four terminal-count modes: wrap, saturate, one-shot and ping-pong. It supports a synchronous load and emits a one-cycle terminal-count pulse. It sits between the board clock and the status LEDs, and also serves as a general-purpose interval timer for other blocks.

---
 rtl/prog_counter.sv | 147 ++++++++++++++
 tb/tb_prog_counter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// prog_counter: prescaled up/down counter with wrap, saturate, one-shot and
// ping-pong terminal behaviour, a synchronous clamped load, and a one-cycle
// terminal-count pulse. The top count bits drive the green status LEDs.
//
// Control strobes: load is a plain single-cycle strobe sampled on the rising
// edge of clk. There is no back-pressure. A load always wins over counting in
// the same cycle.
module prog_counter #(
  parameter int WIDTH      = 24,
  parameter int LED_BITS   = 5,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_down,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic [LED_BITS-1:0]   gleds,
  output logic                  rled,
  output logic                  tc,
  output logic                  dir,
  output logic                  running
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PS_ONE  = PRESCALE_W'(1);

  mode_e                  mode_sel;
  logic [PRESCALE_W-1:0]  pcnt;
  logic [PRESCALE_W-1:0]  pcnt_nxt;
  logic [WIDTH-1:0]       count_nxt;
  logic                   dir_nxt;
  logic                   running_nxt;
  logic                   tc_nxt;
  logic                   advance;
  logic                   tick;
  logic                   go_up;
  logic                   at_top;
  logic                   at_bottom;
  logic                   terminal;
  logic                   limit_zero;
  logic [WIDTH-1:0]       load_clamped;

  assign mode_sel = mode_e'(mode);

  // The prescaler only moves while counting is live and no load is pending.
  assign advance = en & running & ~load;
  assign tick    = advance & (pcnt == prescale);

  // Ping-pong follows its own stored direction; other modes follow the pin.
  assign go_up = (mode_sel == MODE_PINGPONG) ? dir : up_down;

  // ">=" so that a limit lowered below the count makes the next up-tick terminal.
  assign at_top     = (count >= limit);
  assign at_bottom  = (count == '0);
  assign terminal   = go_up ? at_top : at_bottom;
  assign limit_zero = (limit == '0);

  assign load_clamped = (load_val > limit) ? limit : load_val;

  // LEDs mirror the most significant count bits; red LED shows reset.
  assign gleds = count[WIDTH-1 -: LED_BITS];
  assign rled  = ~reset;

  // Next-state selection: load first, then per-tick count/terminal handling.
  always_comb begin
    count_nxt   = count;
    pcnt_nxt    = pcnt;
    dir_nxt     = dir;
    running_nxt = running;
    tc_nxt      = 1'b0;

    if (load) begin
      count_nxt   = load_clamped;
      pcnt_nxt    = '0;
      running_nxt = 1'b1;
      dir_nxt     = up_down;
    end else begin
      if (mode_sel != MODE_PINGPONG) begin
        dir_nxt = up_down;
      end

      if (advance) begin
        pcnt_nxt = tick ? '0 : (pcnt + PS_ONE);
      end

      if (tick) begin
        if (!terminal) begin
          count_nxt = go_up ? (count + CNT_ONE) : (count - CNT_ONE);
        end else begin
          tc_nxt = 1'b1;
          unique case (mode_sel)
            MODE_WRAP: begin
              count_nxt = go_up ? '0 : limit;
            end
            MODE_SAT: begin
              count_nxt = count;
            end
            MODE_ONESHOT: begin
              running_nxt = 1'b0;
            end
            MODE_PINGPONG: begin
              dir_nxt = ~go_up;
              // A zero-length range has nowhere to bounce to, so the count holds.
              if (!limit_zero) begin
                count_nxt = go_up ? (count - CNT_ONE) : CNT_ONE;
              end
            end
            default: begin
              count_nxt = count;
            end
          endcase
        end
      end
    end
  end

  // State registers; reset clears everything immediately, mid-prescale included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      pcnt    <= '0;
      dir     <= 1'b1;
      running <= 1'b1;
      tc      <= 1'b0;
    end else begin
      count   <= count_nxt;
      pcnt    <= pcnt_nxt;
      dir     <= dir_nxt;
      running <= running_nxt;
      tc      <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter at WIDTH=8, LED_BITS=4. Hand-computed vector table,
// directed multi-cycle sequences and a randomized run, all compared against
// a behavioural model of the counter rules.
module tb_prog_counter;

  localparam int W  = 8;
  localparam int LB = 4;
  localparam int PW = 8;
  localparam int EW = 1 + LB + 3 + W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          en       = 1'b0;
  logic          up_down  = 1'b1;
  logic [1:0]    mode     = 2'b00;
  logic          load     = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  limit    = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  count;
  logic [LB-1:0] gleds;
  logic          rled;
  logic          tc;
  logic          dir;
  logic          running;

  prog_counter #(.WIDTH(W), .LED_BITS(LB), .PRESCALE_W(PW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_down  (up_down),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .prescale (prescale),
    .count    (count),
    .gleds    (gleds),
    .rled     (rled),
    .tc       (tc),
    .dir      (dir),
    .running  (running)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  int m_count;
  int m_pcnt;
  bit m_dir;
  bit m_run;
  bit m_tc;

  task automatic model_reset();
    m_count = 0;
    m_pcnt  = 0;
    m_dir   = 1'b1;
    m_run   = 1'b1;
    m_tc    = 1'b0;
  endtask

  // One rising edge of the counter rules, applied to the current inputs.
  task automatic model_edge();
    bit up;
    bit term;
    int lim;
    lim = int'(limit);
    if (!reset) begin
      model_reset();
      return;
    end
    if (load) begin
      m_count = (int'(load_val) > lim) ? lim : int'(load_val);
      m_pcnt  = 0;
      m_run   = 1'b1;
      m_dir   = up_down;
      m_tc    = 1'b0;
      return;
    end
    up = (mode == 2'b11) ? m_dir : up_down;
    if (mode != 2'b11) m_dir = up_down;
    m_tc = 1'b0;
    if (!(en && m_run)) return;
    if (m_pcnt != int'(prescale)) begin
      m_pcnt = m_pcnt + 1;
      return;
    end
    m_pcnt = 0;
    term = up ? (m_count >= lim) : (m_count == 0);
    if (!term) begin
      m_count = up ? m_count + 1 : m_count - 1;
    end else begin
      m_tc = 1'b1;
      case (mode)
        2'b00: m_count = up ? 0 : lim;
        2'b01: ;
        2'b10: m_run = 1'b0;
        default: begin
          m_dir = !up;
          if (lim != 0) m_count = up ? m_count - 1 : 1;
        end
      endcase
    end
  endtask

  function automatic logic [EW-1:0] model_pack();
    logic [W-1:0] c;
    c = m_count[W-1:0];
    return {~reset, c[W-1 -: LB], m_run, m_dir, m_tc, c};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];

  task automatic check_q(string name);
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: expected queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    a = {rled, gleds, running, dir, tc, count};
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got count=%0d tc=%b dir=%b running=%b gleds=%h rled=%b, want count=%0d tc=%b dir=%b running=%b gleds=%h rled=%b",
               name, $time, a[W-1:0], a[W], a[W+1], a[W+2], a[W+3 +: LB], a[EW-1],
               e[W-1:0], e[W], e[W+1], e[W+2], e[W+3 +: LB], e[EW-1]);
    end
  endtask

  task automatic chk(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model and DUT advance together, outputs sampled 1ns later.
  task automatic step(string name);
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_pack());
    #1;
    check_q(name);
  endtask

  task automatic drive(int ld, int lv, int lim, int md, int ud, int e, int ps);
    load     = ld[0];
    load_val = W'(lv);
    limit    = W'(lim);
    mode     = md[1:0];
    up_down  = ud[0];
    en       = e[0];
    prescale = PW'(ps);
  endtask

  // Drop reset between edges and check the asynchronous clear right away.
  task automatic async_reset(string name);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_pack());
    check_q(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int ld; int lv; int lim; int md; int ud; int e; int ps;
    int xc; int xtc; int xdir; int xrun;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl[NV];

  task automatic fill_table();
    // ping-pong, limit 3, load 0: 0,1,2,3,2,1,0,1,2 (up_down pin ignored)
    tbl[0]  = '{1, 0,   3,  3, 1, 1, 0,  0,  0, 1, 1};
    tbl[1]  = '{0, 0,   3,  3, 0, 1, 0,  1,  0, 1, 1};
    tbl[2]  = '{0, 0,   3,  3, 0, 1, 0,  2,  0, 1, 1};
    tbl[3]  = '{0, 0,   3,  3, 0, 1, 0,  3,  0, 1, 1};
    tbl[4]  = '{0, 0,   3,  3, 0, 1, 0,  2,  1, 0, 1};
    tbl[5]  = '{0, 0,   3,  3, 0, 1, 0,  1,  0, 0, 1};
    tbl[6]  = '{0, 0,   3,  3, 0, 1, 0,  0,  0, 0, 1};
    tbl[7]  = '{0, 0,   3,  3, 0, 1, 0,  1,  1, 1, 1};
    tbl[8]  = '{0, 0,   3,  3, 0, 1, 0,  2,  0, 1, 1};
    // load clamp with a would-be tick in the same cycle, then wrap
    tbl[9]  = '{1, 200, 50, 0, 1, 1, 0,  50, 0, 1, 1};
    tbl[10] = '{0, 0,   50, 0, 1, 1, 0,  0,  1, 1, 1};
    tbl[11] = '{0, 0,   50, 0, 1, 1, 0,  1,  0, 1, 1};
    // saturate at 10, tc every terminal tick
    tbl[12] = '{1, 8,   10, 1, 1, 1, 0,  8,  0, 1, 1};
    tbl[13] = '{0, 0,   10, 1, 1, 1, 0,  9,  0, 1, 1};
    tbl[14] = '{0, 0,   10, 1, 1, 1, 0,  10, 0, 1, 1};
    tbl[15] = '{0, 0,   10, 1, 1, 1, 0,  10, 1, 1, 1};
    tbl[16] = '{0, 0,   10, 1, 1, 1, 0,  10, 1, 1, 1};
    // one-shot: single tc, stops; load 2 restarts
    tbl[17] = '{0, 0,   10, 2, 1, 1, 0,  10, 1, 1, 0};
    tbl[18] = '{0, 0,   10, 2, 1, 1, 0,  10, 0, 1, 0};
    tbl[19] = '{1, 2,   10, 2, 1, 1, 0,  2,  0, 1, 1};
    tbl[20] = '{0, 0,   10, 2, 1, 1, 0,  3,  0, 1, 1};
    // down in wrap mode: 0 wraps to limit
    tbl[21] = '{0, 0,   10, 0, 0, 1, 0,  2,  0, 0, 1};
    tbl[22] = '{0, 0,   10, 0, 0, 1, 0,  1,  0, 0, 1};
    tbl[23] = '{0, 0,   10, 0, 0, 1, 0,  0,  0, 0, 1};
    tbl[24] = '{0, 0,   10, 0, 0, 1, 0,  10, 1, 0, 1};
    tbl[25] = '{0, 0,   10, 0, 0, 1, 0,  9,  0, 0, 1};
    // ping-pong with limit 0 holds at 0 but still flips direction
    tbl[26] = '{1, 0,   0,  3, 1, 1, 0,  0,  0, 1, 1};
    tbl[27] = '{0, 0,   0,  3, 1, 1, 0,  0,  1, 0, 1};
    tbl[28] = '{0, 0,   0,  3, 1, 1, 0,  0,  1, 1, 1};
    // limit lowered below count: up is terminal, down decrements
    tbl[29] = '{1, 9,   20, 0, 1, 1, 0,  9,  0, 1, 1};
    tbl[30] = '{0, 0,   5,  0, 1, 1, 0,  0,  1, 1, 1};
    tbl[31] = '{1, 9,   20, 0, 0, 1, 0,  9,  0, 0, 1};
    tbl[32] = '{0, 0,   5,  0, 0, 1, 0,  8,  0, 0, 1};
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int tc_seen;
    model_reset();
    fill_table();

    // Reset state, held across a few edges.
    drive(0, 0, 255, 0, 1, 1, 0);
    #1;
    chk("reset rled", int'(rled), 1);
    chk("reset count", int'(count), 0);
    for (int i = 0; i < 3; i++) step("reset hold");
    chk("reset dir", int'(dir), 1);
    chk("reset running", int'(running), 1);
    reset = 1'b1;

    // Free run: wrap 255 -> 0 at the 256th edge, single tc pulse.
    tc_seen = 0;
    for (int i = 1; i <= 300; i++) begin
      step("free run");
      if (tc) tc_seen++;
      if (i == 255) chk("free run count at 255", int'(count), 255);
      if (i == 256) begin
        chk("free run wrap count", int'(count), 0);
        chk("free run wrap tc", int'(tc), 1);
      end
    end
    chk("free run tc pulses", tc_seen, 1);
    chk("free run end count", int'(count), 300 % 256);
    chk("free run gleds", int'(gleds), (300 % 256) / 16);

    // Prescale 3 with an enable gap in the middle of a prescale period.
    drive(1, 0, 255, 0, 1, 1, 3);
    step("ps load");
    load = 1'b0;
    for (int i = 0; i < 6; i++) step("ps run");
    chk("ps count after 6", int'(count), 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) step("ps frozen");
    chk("ps count frozen", int'(count), 1);
    en = 1'b1;
    step("ps resume");
    chk("ps resume no tick yet", int'(count), 1);
    step("ps resume");
    chk("ps resume partial kept", int'(count), 2);
    for (int i = 0; i < 3; i++) step("ps run");
    chk("ps hold within period", int'(count), 2);
    step("ps run");
    chk("ps next tick", int'(count), 3);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ld, tbl[i].lv, tbl[i].lim, tbl[i].md, tbl[i].ud, tbl[i].e, tbl[i].ps);
      step("table model");
      chk($sformatf("table[%0d] count", i), int'(count), tbl[i].xc);
      chk($sformatf("table[%0d] tc", i), int'(tc), tbl[i].xtc);
      chk($sformatf("table[%0d] dir", i), int'(dir), tbl[i].xdir);
      chk($sformatf("table[%0d] running", i), int'(running), tbl[i].xrun);
    end

    // Async reset with count = 77 and tc high.
    drive(1, 77, 77, 1, 1, 1, 0);
    step("ar load");
    load = 1'b0;
    step("ar sat");
    chk("ar pre count", int'(count), 77);
    chk("ar pre tc", int'(tc), 1);
    async_reset("ar clear");
    chk("ar count", int'(count), 0);
    chk("ar gleds", int'(gleds), 0);
    chk("ar tc", int'(tc), 0);
    chk("ar rled", int'(rled), 1);
    drive(0, 0, 255, 0, 1, 1, 0);
    step("ar held");
    reset = 1'b1;
    step("ar release");
    chk("ar resume count", int'(count), 1);
    chk("ar resume rled", int'(rled), 0);

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 15) == 0);
      load_val = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0)
        limit = ($urandom_range(0, 7) == 0) ? W'(255) : W'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) up_down = ~up_down;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rand async reset");
        step("rand reset held");
        reset = 1'b1;
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
